// File: rtl/ofs_plat_host_ccip_quiesce_pkg.sv
// Shared types for the CCI-P host channel quiesce controller.
//   qstate_e  : controller FSM state, encoding visible on the state port
//   cnt_width : bits needed to hold a count in the range 0..max_val
package ofs_plat_host_ccip_quiesce_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } qstate_e;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ofs_plat_host_ccip_outstanding_counter.sv
// Saturating up/down counter of outstanding lines.
//   clk, reset         : clock, async active-high reset
//   inc_amt / dec_amt  : lines added / retired this cycle (0..7)
//   count              : registered count, 0..MAX_COUNT
//   overflow/underflow : single-cycle pulses, asserted on the cycle whose
//                        result had to be saturated / clamped
module ofs_plat_host_ccip_outstanding_counter
  import ofs_plat_host_ccip_quiesce_pkg::*;
#(
  parameter int MAX_COUNT = 512,
  parameter int W         = cnt_width(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   inc_amt,
  input  logic [2:0]   dec_amt,
  output logic [W-1:0] count,
  output logic         overflow,
  output logic         underflow
);

  // Headroom so count + inc never wraps before the range checks.
  localparam int XW = W + 3;

  logic [W-1:0]  count_q, count_d;
  logic [XW-1:0] sum;

  always_comb begin
    sum       = XW'(count_q) + XW'(inc_amt);
    count_d   = count_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    // Increment and decrement apply together; only the net result is bounded.
    if (sum < XW'(dec_amt)) begin
      count_d   = '0;
      underflow = 1'b1;
    end else if ((sum - XW'(dec_amt)) > XW'(MAX_COUNT)) begin
      count_d  = W'(MAX_COUNT);
      overflow = 1'b1;
    end else begin
      count_d = W'(sum - XW'(dec_amt));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ofs_plat_host_ccip_quiesce_ctrl.sv
// Quiesce controller for a CCI-P host channel. On quiesce_req it raises
// almost-full to the AFU, keeps forwarding slack requests while tracking
// outstanding read/write lines, and declares QUIESCED after GRACE_CYCLES
// consecutive fully idle cycles. In QUIESCED new requests are dropped.
//   in : clk, reset, quiesce_req, AFU c0/c1 requests, FIU c0/c1 responses,
//        FIU almost-full
//   out: gated FIU tx valids, AFU almost-full, quiesced, state,
//        rd/wr outstanding counts, sticky error flags
module ofs_plat_host_ccip_quiesce_ctrl
  import ofs_plat_host_ccip_quiesce_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 512,
  parameter int GRACE_CYCLES    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    quiesce_req,
  input  logic                                    afu_c0_req_valid,
  input  logic [2:0]                              afu_c0_req_lines,
  input  logic                                    afu_c1_req_valid,
  input  logic                                    fiu_c0_rsp_valid,
  input  logic                                    fiu_c1_rsp_valid,
  input  logic [2:0]                              fiu_c1_rsp_lines,
  input  logic                                    fiu_c0_almost_full,
  input  logic                                    fiu_c1_almost_full,
  output logic                                    fiu_c0_tx_valid,
  output logic                                    fiu_c1_tx_valid,
  output logic                                    afu_c0_almost_full,
  output logic                                    afu_c1_almost_full,
  output logic                                    quiesced,
  output logic [1:0]                              state,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]   rd_outstanding,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]   wr_outstanding,
  output logic                                    err_overflow,
  output logic                                    err_underflow,
  output logic                                    err_dropped
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int GW = cnt_width(GRACE_CYCLES);

  qstate_e       state_q, state_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          err_drop_q, err_drop_d;

  logic          fwd_c0, fwd_c1, idle;
  logic [2:0]    rd_inc, rd_dec, wr_inc, wr_dec;
  logic          rd_ovf, rd_unf, wr_ovf, wr_unf;

  // Requests pass straight through unless the channel is fully quiesced.
  assign fwd_c0          = afu_c0_req_valid && (state_q != ST_QUIESCED);
  assign fwd_c1          = afu_c1_req_valid && (state_q != ST_QUIESCED);
  assign fiu_c0_tx_valid = fwd_c0;
  assign fiu_c1_tx_valid = fwd_c1;

  assign afu_c0_almost_full = fiu_c0_almost_full || (state_q != ST_RUN);
  assign afu_c1_almost_full = fiu_c1_almost_full || (state_q != ST_RUN);

  assign rd_inc = fwd_c0 ? afu_c0_req_lines : 3'd0;
  assign rd_dec = fiu_c0_rsp_valid ? 3'd1 : 3'd0;
  assign wr_inc = fwd_c1 ? 3'd1 : 3'd0;
  assign wr_dec = fiu_c1_rsp_valid ? fiu_c1_rsp_lines : 3'd0;

  ofs_plat_host_ccip_outstanding_counter #(.MAX_COUNT(MAX_OUTSTANDING), .W(CW)) u_rd_cnt (
    .clk(clk), .reset(reset), .inc_amt(rd_inc), .dec_amt(rd_dec),
    .count(rd_outstanding), .overflow(rd_ovf), .underflow(rd_unf)
  );

  ofs_plat_host_ccip_outstanding_counter #(.MAX_COUNT(MAX_OUTSTANDING), .W(CW)) u_wr_cnt (
    .clk(clk), .reset(reset), .inc_amt(wr_inc), .dec_amt(wr_dec),
    .count(wr_outstanding), .overflow(wr_ovf), .underflow(wr_unf)
  );

  // Idle means nothing tracked and nothing moving in either direction.
  assign idle = (rd_outstanding == '0) && (wr_outstanding == '0) &&
                !afu_c0_req_valid && !afu_c1_req_valid &&
                !fiu_c0_rsp_valid && !fiu_c1_rsp_valid;

  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    unique case (state_q)
      ST_RUN: begin
        grace_d = '0;
        if (quiesce_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!quiesce_req) begin
          state_d = ST_RUN;
          grace_d = '0;
        end else if (!idle) begin
          grace_d = '0;
        end else if (grace_q == GW'(GRACE_CYCLES - 1)) begin
          // This cycle completes the idle run.
          state_d = ST_QUIESCED;
          grace_d = '0;
        end else begin
          grace_d = grace_q + GW'(1);
        end
      end
      ST_QUIESCED: begin
        grace_d = '0;
        if (!quiesce_req) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        grace_d = '0;
      end
    endcase
  end

  always_comb begin
    err_ovf_d  = err_ovf_q || rd_ovf || wr_ovf;
    err_unf_d  = err_unf_q || rd_unf || wr_unf;
    err_drop_d = err_drop_q ||
                 ((state_q == ST_QUIESCED) && (afu_c0_req_valid || afu_c1_req_valid));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      grace_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grace_q    <= grace_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign state         = state_q;
  assign quiesced      = (state_q == ST_QUIESCED);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_dropped   = err_drop_q;

endmodule

// File: doc/ofs_plat_host_ccip_quiesce_ctrl.md
OFS_PLAT_HOST_CCIP_QUIESCE_CTRL -- requirements
Module: ofs_plat_host_ccip_quiesce_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 512, meaning max tracked lines per channel.
REQ-002 SHALL have parameter GRACE_CYCLES, default 16, meaning idle cycles required with zero outstanding before QUIESCED.
REQ-003 SHALL have ports (CW = $clog2(MAX_OUTSTANDING+1)):
  clk  in  1  sole clock
  reset  in  1  asynchronous, active-high
  quiesce_req  in  1  level; 1 = stop the host channel
  afu_c0_req_valid  in  1  AFU read request
  afu_c0_req_lines  in  3  lines in read request, 1/2/4
  afu_c1_req_valid  in  1  AFU write request, one line
  fiu_c0_rsp_valid  in  1  read-data line returned (MMIO excluded)
  fiu_c1_rsp_valid  in  1  write response
  fiu_c1_rsp_lines  in  3  lines acknowledged by packed response, 1..4
  fiu_c0_almost_full  in  1  FIU c0 almost-full
  fiu_c1_almost_full  in  1  FIU c1 almost-full
  fiu_c0_tx_valid  out  1  gated read request to FIU
  fiu_c1_tx_valid  out  1  gated write request to FIU
  afu_c0_almost_full  out  1  almost-full presented to AFU
  afu_c1_almost_full  out  1  almost-full presented to AFU
  quiesced  out  1  channel idle, all requests blocked
  state  out  2  current FSM state
  rd_outstanding  out  CW  outstanding read lines
  wr_outstanding  out  CW  outstanding write lines
  err_overflow  out  1  sticky, counter saturated
  err_underflow  out  1  sticky, response at zero count
  err_dropped  out  1  sticky, request dropped in QUIESCED

Function
REQ-004 SHALL implement FSM states RUN=0, DRAIN=1, QUIESCED=2; state output SHALL be the state register.
REQ-005 RUN -> DRAIN when quiesce_req=1.
REQ-006 DRAIN -> RUN when quiesce_req=0 (abort); grace counter cleared.
REQ-007 DRAIN: grace counter increments each cycle with both counters zero and no request or response valid; any other cycle clears it; DRAIN -> QUIESCED on the cycle the counter reaches GRACE_CYCLES-1 and the idle condition still holds.
REQ-008 QUIESCED -> RUN when quiesce_req=0; otherwise hold.
REQ-009 fiu_cX_tx_valid SHALL equal afu_cX_req_valid when state != QUIESCED, else 0; zero-cycle combinational path.
REQ-010 afu_cX_almost_full SHALL equal fiu_cX_almost_full OR (state != RUN).
REQ-011 Requests arriving in DRAIN (post-almost-full slack) SHALL be forwarded and counted.
REQ-012 Requests in QUIESCED SHALL be dropped, not counted, and set err_dropped.
REQ-013 rd_outstanding next = current + (c0 req ? lines : 0) - (c0 rsp ? 1 : 0); simultaneous request and response SHALL both apply in the same cycle.
REQ-014 wr_outstanding next = current + (c1 req ? 1 : 0) - (c1 rsp ? rsp_lines : 0).
REQ-015 Result above MAX_OUTSTANDING SHALL saturate at MAX_OUTSTANDING and set err_overflow.
REQ-016 Result below zero SHALL clamp to 0 and set err_underflow.
REQ-017 Responses SHALL be counted in every state, including QUIESCED.
REQ-018 quiesced SHALL be 1 exactly when state == QUIESCED; counters and outputs are registered, one-cycle update latency.
REQ-019 Sticky error flags SHALL clear only on reset.

Reset
REQ-020 reset SHALL asynchronously force state=RUN, both counters=0, grace counter=0, all error flags=0, quiesced=0.
REQ-021 Reset asserted mid-DRAIN SHALL discard all tracking; first post-reset cycle is RUN with quiesce_req sampled normally.

Structure
REQ-022 Package ofs_plat_host_ccip_quiesce_pkg SHALL hold the state enum typedef and a counter-width function.
REQ-023 Counter logic SHALL be one sub-module, ofs_plat_host_ccip_outstanding_counter (saturating up/down, width-parameterized, overflow/underflow pulses), instantiated twice.

Verification
REQ-024 RUN, 3 reads of 4 lines, then 12 single c0 responses -> rd_outstanding 4,8,12 then decrements to 0; no errors.
REQ-025 quiesce_req=1 with rd_outstanding=2 -> afu_c0_almost_full=1 next cycle; 2 responses then 16 idle cycles -> quiesced=1 on the 16th idle cycle.
REQ-026 Simultaneous c1 request and packed response rsp_lines=4 with wr_outstanding=5 -> wr_outstanding=2.
REQ-027 QUIESCED, afu_c0_req_valid=1 -> fiu_c0_tx_valid=0, err_dropped=1, rd_outstanding unchanged.
REQ-028 c1 response at wr_outstanding=0 -> stays 0, err_underflow=1; 513th outstanding read line -> rd_outstanding=512, err_overflow=1.
REQ-029 reset pulse during DRAIN with counters nonzero -> state=RUN, counters=0 immediately, no clock edge required.
